// File: rtl/gaussian_row_scheduler_if.sv
// rtl/gaussian_row_scheduler_if.sv - source/engine handshake bundle for the Gaussian row scheduler
interface gaussian_row_scheduler_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic              valid0;
    logic [DATA_W-1:0] din0;
    logic              rd_en0;
    logic              valid1;
    logic [DATA_W-1:0] din1;
    logic              rd_en1;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_sol;
    logic              out_eol;
    logic              busy;
    logic [1:0]        frame_done;

    modport slave (
        input  enable, valid0, din0, valid1, din1, out_ready,
        output rd_en0, rd_en1, out_valid, out_data, out_src, out_sol, out_eol, busy, frame_done
    );

    modport master (
        output enable, valid0, din0, valid1, din1, out_ready,
        input  rd_en0, rd_en1, out_valid, out_data, out_src, out_sol, out_eol, busy, frame_done
    );
endinterface

// File: rtl/gaussian_row_scheduler.sv
// rtl/gaussian_row_scheduler.sv - whole-row arbiter of two octave streams onto one blur engine
module gaussian_row_scheduler #(
    parameter int DATA_W  = 8,
    parameter int LINE_W  = 400,
    parameter int PAD_LEN = 1,
    parameter int ROWS    = 300,
    parameter int CNT_W   = 9
) (
    input  logic clk,
    input  logic rst,
    gaussian_row_scheduler_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_PAD    = 2'd2;

    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(LINE_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
    localparam logic [3:0]       PAD_LAST = 4'((PAD_LEN == 0) ? 0 : PAD_LEN - 1);
    localparam bit               HAS_PAD  = (PAD_LEN != 0);

    logic [1:0]        state;
    logic              grant_q;
    logic              last_grant;
    logic [CNT_W-1:0]  pix_cnt;
    logic [3:0]        pad_cnt;
    logic [CNT_W-1:0]  row_cnt0;
    logic [CNT_W-1:0]  row_cnt1;
    logic [1:0]        frame_done_q;

    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              ov;
    logic [DATA_W-1:0] od;
    logic              sol;
    logic              eol;
    logic              pop0;
    logic              pop1;
    logic              xfer;
    logic              row_end;
    logic              grant_req;
    logic              grant_src;

    always_comb begin
        src_valid = grant_q ? bus.valid1 : bus.valid0;
        src_data  = grant_q ? bus.din1 : bus.din0;
        ov   = 1'b0;
        od   = '0;
        sol  = 1'b0;
        eol  = 1'b0;
        pop0 = 1'b0;
        pop1 = 1'b0;
        case (state)
            S_STREAM: begin
                ov   = src_valid;
                od   = src_data;
                pop0 = !grant_q && src_valid && bus.out_ready;
                pop1 = grant_q && src_valid && bus.out_ready;
                sol  = src_valid && (pix_cnt == '0);
                eol  = src_valid && (pix_cnt == PIX_LAST) && !HAS_PAD;
            end
            S_PAD: begin
                ov  = 1'b1;
                eol = (pad_cnt == PAD_LAST);
            end
            default: ;
        endcase
        xfer      = ov && bus.out_ready;
        row_end   = xfer && eol;
        grant_req = (state == S_IDLE) && bus.enable && (bus.valid0 || bus.valid1);
        // Contention alternates; a lone requester always wins.
        grant_src = (bus.valid0 && bus.valid1) ? !last_grant : bus.valid1;
    end

    assign bus.out_valid  = ov;
    assign bus.out_data   = od;
    assign bus.out_src    = ov && grant_q;
    assign bus.out_sol    = sol;
    assign bus.out_eol    = eol;
    assign bus.rd_en0     = pop0;
    assign bus.rd_en1     = pop1;
    assign bus.busy       = (state != S_IDLE);
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant   <= 1'b1;
            pix_cnt      <= '0;
            pad_cnt      <= '0;
            row_cnt0     <= '0;
            row_cnt1     <= '0;
            frame_done_q <= 2'b00;
        end else begin
            frame_done_q <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (grant_req) begin
                        grant_q <= grant_src;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt <= '0;
                            state   <= HAS_PAD ? S_PAD : S_IDLE;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (xfer) begin
                        if (pad_cnt == PAD_LAST) begin
                            pad_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            pad_cnt <= pad_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (row_end) begin
                last_grant <= grant_q;
                if (grant_q) begin
                    row_cnt1 <= (row_cnt1 == ROW_LAST) ? '0 : row_cnt1 + 1'b1;
                    frame_done_q[1] <= (row_cnt1 == ROW_LAST);
                end else begin
                    row_cnt0 <= (row_cnt0 == ROW_LAST) ? '0 : row_cnt0 + 1'b1;
                    frame_done_q[0] <= (row_cnt0 == ROW_LAST);
                end
            end
        end
    end
endmodule

// File: doc/gaussian_row_scheduler.md
Name: gaussian_row_scheduler

Overview:
- Arbitrates two down-sampled pixel streams (octave 0 and octave 1) onto one shared Gaussian blur engine.
- Grants are whole rows: once a row is granted, all of it goes out before the other source is served.
- Each row is followed by PAD_LEN zero pixels, which the blur kernel uses as row-boundary padding.
- Sits between the per-octave down-sampler FIFOs (first-word-fall-through) and the Gaussian wrapper input.

Parameters:
- DATA_W, 8: pixel width.
- LINE_W, 400: data pixels per row.
- PAD_LEN, 1: zero pixels appended per row. Legal range 0..15.
- ROWS, 300: rows per frame, per source.
- CNT_W, 9: width of the pixel and row counters. Must hold LINE_W-1 and ROWS-1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: when low, no new row grants are issued; a row in progress still completes.
- valid0, in, 1: source 0 FIFO has data.
- din0, in, DATA_W: source 0 head pixel.
- rd_en0, out, 1: pop source 0.
- valid1, in, 1: source 1 FIFO has data.
- din1, in, DATA_W: source 1 head pixel.
- rd_en1, out, 1: pop source 1.
- out_ready, in, 1: Gaussian engine can accept a pixel this cycle.
- out_valid, out, 1: pixel offered to the engine.
- out_data, out, DATA_W: pixel value.
- out_src, out, 1: source index of the current row.
- out_sol, out, 1: first pixel of a row.
- out_eol, out, 1: last pixel of a row, counting padding.
- busy, out, 1: state is not IDLE.
- frame_done, out, 2: one-cycle pulse per source when its last row completes.

Behaviour:
- Transfer rule: a transfer occurs when out_valid and out_ready are both high in the same cycle.
- Reset values:
  - State IDLE, pix_cnt 0, pad_cnt 0, row_cnt0 and row_cnt1 0, last_grant 1 (so source 0 wins first).
  - rd_en0, rd_en1, out_valid, out_sol, out_eol, busy, frame_done all 0.
  - out_data 0, out_src 0.
- States: IDLE, STREAM, PAD.
- IDLE:
  - out_valid is 0.
  - If enable and exactly one valid is high, grant that source.
  - If both are high, grant the source != last_grant.
  - A grant latches grant_q and moves to STREAM next cycle.
  - There is no same-cycle data transfer in IDLE. Grant latency is 1 cycle.
- STREAM:
  - out_valid = valid[grant_q].
  - out_data = din[grant_q].
  - rd_en[grant_q] = valid[grant_q] & out_ready. The other rd_en is 0.
  - All of these are combinational pass-through; there is no added data latency.
  - pix_cnt increments on each transfer.
  - Transfer at pix_cnt == LINE_W-1: pix_cnt goes to 0, and the state goes to PAD, or ends the row if PAD_LEN == 0.
  - The source dropping valid mid-row stalls the row (out_valid 0). There is no preemption, even if the other source is valid.
- PAD:
  - out_valid = 1, out_data = 0. No rd_en.
  - pad_cnt increments on each transfer.
  - Transfer at pad_cnt == PAD_LEN-1 ends the row; pad_cnt goes to 0.
- Row end:
  - Next state is IDLE and last_grant is set to grant_q.
  - row_cnt[grant_q] increments.
  - If row_cnt[grant_q] was ROWS-1, it wraps to 0 and frame_done[grant_q] pulses high on the following cycle.
- Flags:
  - out_sol = STREAM & pix_cnt == 0 & out_valid.
  - out_eol is high on the final transfer-eligible pixel of the row (the last pad pixel, or the last data pixel when PAD_LEN == 0).
  - out_src = grant_q whenever out_valid is high, and 0 otherwise.
- Backpressure: out_ready low freezes pix_cnt and pad_cnt and holds the outputs, with no pops. The data stays at the FIFO head.
- Back-to-back rows: there is always one IDLE cycle between rows. This is acceptable because 1/(LINE_W+PAD_LEN+1) throughput loss is within budget.
- enable low in IDLE: stay in IDLE. enable low in STREAM or PAD: no effect until row end.
- Reset mid-row: abandon the row with no further pops. The downstream engine flushes on its own reset.
- Counters never exceed their limits. Reaching any other counter value is a design error (bench assertion).

Test Plan:
- Only source 0 valid, out_ready = 1, LINE_W = 400, PAD_LEN = 1 -> 400 pops of din0 in order, then one zero pixel.
  - out_sol on pixel 0; out_eol on the pad pixel.
  - 401 transfers, then 1 IDLE cycle.
- Both sources always valid -> rows alternate 0,1,0,1, shown by out_src. Source 0 goes first after reset. Two consecutive grants to the same source are a failure.
- out_ready toggled 1,0 every cycle mid-row -> one pop per two cycles; no pixel duplicated or dropped (scoreboard on din sequence); pix_cnt held during low cycles.
- valid0 low for 10 cycles at pixel 200 while valid1 is high -> out_valid low for 10 cycles, no rd_en1, and the row resumes at pixel 200 from source 0.
- ROWS = 3, source 0 only -> frame_done[0] pulses exactly once, 1 cycle after the third row's eol. The fourth row starts with row_cnt0 = 0.
- rst asserted at pixel 150 of a row -> next cycle all outputs are at reset values; after release the first grant goes to source 0, with a fresh out_sol.
